stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
- Decode-stage sequencer that expands CALL, RET, RTI and hardware interrupts into multi-cycle push/pop micro-steps.
- Drives the decode/execute pipeline register fields first_time_call, first_time_ret, first_time_int, the push/pop enable and the flush count.
- Holds fetch while a sequence runs.
- Sits between the instruction decoder and the decode/execute buffer, so it is the producer side of those buffer fields.

Parameters:
- PC_W, 32, program-counter width
- DATA_W, 16, stack word width (PC is pushed as two words)
- FLAG_W, 3, condition-code flags width
- FLUSH_CNT, 2, pipeline flush count emitted at sequence end

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hazard stall; freezes the FSM and all outputs
- is_call  in  1  decoded CALL in decode stage
- is_ret  in  1  decoded RET
- is_rti  in  1  decoded RTI
- intr  in  1  external interrupt request, level
- pc  in  PC_W  return address supplied by decode
- flags  in  FLAG_W  current CCR
- busy  out  1  hold fetch/PC and decode input
- first_time_call  out  2  CALL step code
- first_time_ret  out  2  RET/RTI step code
- first_time_int  out  2  INT step code
- push_pop  out  2  00 none, 01 push, 10 pop
- push_data  out  DATA_W  word to push
- flush_num  out  2  flush count, valid with final step

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pending interrupt cleared; all outputs 0 (busy, codes, push_pop, push_data, flush_num). Reset mid-sequence aborts the sequence immediately; no further steps are issued.
- States: IDLE, CALL_H, CALL_L, RET_L, RET_H, RTI_F, RTI_L, RTI_H, INT_H, INT_L, INT_F.
- Step outputs are registered (Moore). Latency: start accepted in cycle N, first step visible in cycle N+1, one step per non-stalled cycle.
- busy = start_accepted_this_cycle OR state!=IDLE. Combinational, so fetch holds in the accept cycle.
- Start priority in IDLE with stall_i=0: is_call > is_ret > is_rti > pending interrupt. An instruction start beats an interrupt in the same cycle; the interrupt stays pending.
- Capture on start: pc and flags are latched into internal registers. Later changes on the inputs are ignored until IDLE.
- CALL: CALL_H (push_pop=01, push_data=pc[31:16], code 01), then CALL_L (push pc[15:0], code 10, flush_num=FLUSH_CNT), then IDLE.
- RET: RET_L (push_pop=10, first_time_ret=01), then RET_H (pop, code 10, flush_num=FLUSH_CNT), then IDLE.
- RTI: RTI_F (pop, first_time_ret=11), RTI_L (01), RTI_H (10, flush_num=FLUSH_CNT), then IDLE.
- INT: INT_H (push pc[31:16], first_time_int=01), INT_L (push pc[15:0], 10), INT_F (push zero-extended flags, 11, flush_num=FLUSH_CNT), then IDLE.
- Push order is high, low, flags; pop order is the exact reverse (LIFO).
- Interrupt pending latch:
  - Set on any cycle with intr=1.
  - Cleared on entry to INT_H.
  - Not accepted while a sequence is in progress; taken from IDLE in the first non-stalled cycle without an instruction start.
- stall_i=1: state, latches and all registered outputs hold their values; no start is accepted. The pending interrupt latch still sets.
- In IDLE, codes, push_pop and flush_num are 0; push_data holds its last value.
- Codes of the sequences not in progress are always 00.

Decomposition:
- Shared package holds:
  - state enum
  - push_pop encodings (PP_NONE, PP_PUSH, PP_POP)
  - step-code constants (STEP_HI=01, STEP_LO=10, STEP_FLAGS=11)
  - FLUSH_CNT default
- No sub-module is needed; the single FSM plus the capture registers fit in one module.

Test Plan:
- is_call=1 with pc=0x0001_2345 for one cycle, then stall_i=0 → busy=1 in that cycle. Next cycle: push_pop=01, push_data=0x0001, first_time_call=01. Then push_data=0x2345, code 10, flush_num=2. Then IDLE with all codes 0.
- is_rti=1 → first_time_ret = 11, 01, 10 on consecutive cycles, push_pop=10 each cycle, flush_num=2 only on the third.
- intr=1 and is_call=1 in the same IDLE cycle, pc=0x0000_0010, flags=3'b101 → the full CALL sequence runs first. Then INT pushes 0x0000, 0x0010 (or the newly captured pc), then 0x0005 with first_time_int = 01, 10, 11.
- stall_i=1 for 3 cycles while in CALL_L → all outputs frozen for those 3 cycles, then CALL_L completes exactly once.
- rst_n=0 asynchronously during INT_L → outputs go to 0 without waiting for a clock edge. After release, state is IDLE and there is no pending interrupt unless intr is still high.
- is_call=1 and is_ret=1 together → the CALL sequence runs and RET is ignored.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// Shared types and constants for the decode-stage stack sequencer.
package stack_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CALL_H,
    CALL_L,
    RET_L,
    RET_H,
    RTI_F,
    RTI_L,
    RTI_H,
    INT_H,
    INT_L,
    INT_F
  } state_t;

  localparam logic [1:0] PP_NONE = 2'b00;
  localparam logic [1:0] PP_PUSH = 2'b01;
  localparam logic [1:0] PP_POP  = 2'b10;

  localparam logic [1:0] STEP_NONE  = 2'b00;
  localparam logic [1:0] STEP_HI    = 2'b01;
  localparam logic [1:0] STEP_LO    = 2'b10;
  localparam logic [1:0] STEP_FLAGS = 2'b11;

  localparam int unsigned FLUSH_CNT_DEF = 2;

endpackage

// File: rtl/stack_sequencer.sv
// Expands CALL/RET/RTI and hardware interrupts into registered push/pop
// micro-steps for the decode/execute buffer, holding fetch while busy.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FLAG_W    = 3,
  parameter int unsigned FLUSH_CNT = FLUSH_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic              is_rti,
  input  logic              intr,
  input  logic [PC_W-1:0]   pc,
  input  logic [FLAG_W-1:0] flags,
  output logic              busy,
  output logic [1:0]        first_time_call,
  output logic [1:0]        first_time_ret,
  output logic [1:0]        first_time_int,
  output logic [1:0]        push_pop,
  output logic [DATA_W-1:0] push_data,
  output logic [1:0]        flush_num
);

  localparam logic [1:0] FLUSH_V = 2'(FLUSH_CNT);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_src;
  logic [FLAG_W-1:0]   flags_q, flags_src;
  logic                int_pend_q;
  logic                accept;
  logic                enter_int;
  logic [1:0]          call_d, ret_d, int_d, pp_d, flush_d;
  logic [DATA_W-1:0]   data_d;

  // Start acceptance, next state, and the step outputs of the next state.
  // Outputs are computed for state_d so they appear registered with that state;
  // in the accept cycle the live inputs stand in for the not-yet-captured values.
  always_comb begin
    accept    = (state_q == IDLE) && !stall_i &&
                (is_call || is_ret || is_rti || int_pend_q);
    busy      = accept || (state_q != IDLE);
    pc_src    = accept ? pc : pc_q;
    flags_src = accept ? flags : flags_q;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!stall_i) begin
          if (is_call)         state_d = CALL_H;
          else if (is_ret)     state_d = RET_L;
          else if (is_rti)     state_d = RTI_F;
          else if (int_pend_q) state_d = INT_H;
        end
      end
      CALL_H:  state_d = CALL_L;
      CALL_L:  state_d = IDLE;
      RET_L:   state_d = RET_H;
      RET_H:   state_d = IDLE;
      RTI_F:   state_d = RTI_L;
      RTI_L:   state_d = RTI_H;
      RTI_H:   state_d = IDLE;
      INT_H:   state_d = INT_L;
      INT_L:   state_d = INT_F;
      INT_F:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_int = accept && (state_d == INT_H);

    call_d  = STEP_NONE;
    ret_d   = STEP_NONE;
    int_d   = STEP_NONE;
    pp_d    = PP_NONE;
    flush_d = 2'b00;
    data_d  = push_data;
    case (state_d)
      CALL_H: begin call_d = STEP_HI; pp_d = PP_PUSH; data_d = pc_src[DATA_W +: DATA_W]; end
      CALL_L: begin call_d = STEP_LO; pp_d = PP_PUSH; data_d = pc_src[0 +: DATA_W]; flush_d = FLUSH_V; end
      RET_L:  begin ret_d = STEP_HI;    pp_d = PP_POP; end
      RET_H:  begin ret_d = STEP_LO;    pp_d = PP_POP; flush_d = FLUSH_V; end
      RTI_F:  begin ret_d = STEP_FLAGS; pp_d = PP_POP; end
      RTI_L:  begin ret_d = STEP_HI;    pp_d = PP_POP; end
      RTI_H:  begin ret_d = STEP_LO;    pp_d = PP_POP; flush_d = FLUSH_V; end
      INT_H:  begin int_d = STEP_HI; pp_d = PP_PUSH; data_d = pc_src[DATA_W +: DATA_W]; end
      INT_L:  begin int_d = STEP_LO; pp_d = PP_PUSH; data_d = pc_src[0 +: DATA_W]; end
      INT_F:  begin int_d = STEP_FLAGS; pp_d = PP_PUSH; data_d = DATA_W'(flags_src); flush_d = FLUSH_V; end
      default: ;
    endcase
  end

  // State, capture and output registers; stall freezes all but the pending latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pc_q            <= '0;
      flags_q         <= '0;
      int_pend_q      <= 1'b0;
      first_time_call <= '0;
      first_time_ret  <= '0;
      first_time_int  <= '0;
      push_pop        <= '0;
      push_data       <= '0;
      flush_num       <= '0;
    end else begin
      int_pend_q <= enter_int ? 1'b0 : (int_pend_q | intr);
      if (!stall_i) begin
        state_q         <= state_d;
        first_time_call <= call_d;
        first_time_ret  <= ret_d;
        first_time_int  <= int_d;
        push_pop        <= pp_d;
        push_data       <= data_d;
        flush_num       <= flush_d;
        if (accept) begin
          pc_q    <= pc;
          flags_q <= flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: a step-list reference model queues the
// expected micro-steps; a monitor pops and compares each presented step.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, is_call, is_ret, is_rti, intr;
  logic [31:0] pc;
  logic [2:0]  flags;
  logic        busy;
  logic [1:0]  first_time_call, first_time_ret, first_time_int, push_pop, flush_num;
  logic [15:0] push_data;

  stack_sequencer #(.PC_W(32), .DATA_W(16), .FLAG_W(3), .FLUSH_CNT(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .is_call(is_call),
    .is_ret(is_ret), .is_rti(is_rti), .intr(intr), .pc(pc), .flags(flags),
    .busy(busy), .first_time_call(first_time_call), .first_time_ret(first_time_ret),
    .first_time_int(first_time_int), .push_pop(push_pop), .push_data(push_data),
    .flush_num(flush_num)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  c, r, i, pp, f;
    logic [15:0] d;
  } step_t;

  step_t       exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // model: steps still owed by the current sequence, its kind, pending interrupt
  int unsigned remaining = 0;
  int unsigned kind = 0;  // 0 none, 1 call, 2 ret, 3 rti, 4 int
  bit          pending = 1'b0;
  logic [31:0] cur_pc = '0;
  logic [2:0]  cur_fl = '0;

  function automatic step_t mk(input logic [1:0] c, r, i, pp, f, input logic [15:0] d);
    step_t s;
    s.c = c; s.r = r; s.i = i; s.pp = pp; s.f = f; s.d = d;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One decode cycle: drive inputs at the falling edge, check busy, advance the model.
  task automatic drive(input bit st, input bit c, input bit r, input bit t, input bit it);
    bit acc;
    stall_i = st; is_call = c; is_ret = r; is_rti = t; intr = it;
    pc = cur_pc; flags = cur_fl;
    #1;
    acc = !st && remaining == 0 && (c || r || t || pending);
    check("busy", 32'(busy), 32'(acc || remaining > 0));
    if (!st && remaining > 0) begin
      remaining--;
      if (remaining == 0) kind = 0;
    end else if (acc) begin
      if (c) begin
        kind = 1; remaining = 2;
        exp_q.push_back(mk(2'd1, 2'd0, 2'd0, 2'd1, 2'd0, cur_pc[31:16]));
        exp_q.push_back(mk(2'd2, 2'd0, 2'd0, 2'd1, 2'd2, cur_pc[15:0]));
      end else if (r) begin
        kind = 2; remaining = 2;
        exp_q.push_back(mk(2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 16'h0));
        exp_q.push_back(mk(2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 16'h0));
      end else if (t) begin
        kind = 3; remaining = 3;
        exp_q.push_back(mk(2'd0, 2'd3, 2'd0, 2'd2, 2'd0, 16'h0));
        exp_q.push_back(mk(2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 16'h0));
        exp_q.push_back(mk(2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 16'h0));
      end else begin
        kind = 4; remaining = 3;
        exp_q.push_back(mk(2'd0, 2'd0, 2'd1, 2'd1, 2'd0, cur_pc[31:16]));
        exp_q.push_back(mk(2'd0, 2'd0, 2'd2, 2'd1, 2'd0, cur_pc[15:0]));
        exp_q.push_back(mk(2'd0, 2'd0, 2'd3, 2'd1, 2'd2, {13'b0, cur_fl}));
      end
    end
    if (acc && !c && !r && !t) pending = 1'b0;
    else pending = pending | it;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: after each rising edge, pop and compare a presented step, check
  // idle outputs are zero, and check that a stalled edge changed nothing.
  initial begin : monitor
    bit    adv;
    step_t snap, act;
    snap = '0;
    forever begin
      @(posedge clk);
      adv = rst_n && !stall_i;
      #2;
      act = mk(first_time_call, first_time_ret, first_time_int, push_pop, flush_num, push_data);
      if (rst_n) begin
        if (!adv) begin
          check("frozen", 32'(act), 32'(snap));
        end else if (push_pop != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_step", 32'(push_pop), 32'd0);
          end else begin
            step_t e;
            e = exp_q.pop_front();
            check("step_ctl", {22'b0, act.c, act.r, act.i, act.pp, act.f},
                              {22'b0, e.c, e.r, e.i, e.pp, e.f});
            if (e.pp == 2'd1) check("push_data", 32'(act.d), 32'(e.d));
          end
        end else begin
          check("idle_zero", {24'b0, act.c, act.r, act.i, act.f}, 32'd0);
        end
      end
      snap = act;
    end
  end

  initial begin
    rst_n = 1'b0;
    stall_i = 0; is_call = 0; is_ret = 0; is_rti = 0; intr = 0; pc = '0; flags = '0;
    #3;
    check("reset_out", {busy, first_time_call, first_time_ret, first_time_int,
                        push_pop, flush_num, push_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // CALL with a known return address
    cur_pc = 32'h0001_2345; cur_fl = 3'b000;
    drive(0, 1, 0, 0, 0);
    idle(3);

    // RTI three-pop sequence
    drive(0, 0, 0, 1, 0);
    idle(4);

    // CALL and interrupt together: CALL first, interrupt stays pending
    cur_pc = 32'h0000_0010; cur_fl = 3'b101;
    drive(0, 1, 0, 0, 1);
    idle(8);

    // stall for three cycles while in CALL_L
    cur_pc = 32'hABCD_1234;
    drive(0, 1, 0, 0, 0);
    idle(1);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0);
    idle(3);

    // CALL beats RET
    cur_pc = 32'h5555_AAAA;
    drive(0, 1, 1, 0, 0);
    idle(4);

    // asynchronous reset in the middle of INT_L
    cur_pc = 32'h1357_9BDF; cur_fl = 3'b011;
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 10 && !(kind == 4 && remaining == 2); k++) idle(1);
    check("reached_int_l", 32'(kind == 4 && remaining == 2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {busy, first_time_call, first_time_ret, first_time_int,
                          push_pop, flush_num, push_data}, 32'd0);
    exp_q.delete();
    remaining = 0; kind = 0; pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit st, c, r, t, it;
      st = ($urandom_range(0, 99) < 20);
      c  = ($urandom_range(0, 99) < 12);
      r  = ($urandom_range(0, 99) < 12);
      t  = ($urandom_range(0, 99) < 10);
      it = ($urandom_range(0, 99) < 6);
      cur_pc = $urandom;
      cur_fl = 3'($urandom);
      drive(st, c, r, t, it);
    end

    // drain any remaining sequence and pending interrupt
    for (int k = 0; k < 30 && (remaining != 0 || pending); k++) idle(1);
    idle(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
